midi_poly: RTL

- Parametrised successor to the mono MIDI decoder.
- Parses a byte stream from the UART receiver and maintains a polyphonic note table of VOICES slots.
- Also tracks program change and pitch bend, filters on one MIDI channel (or omni), and supports running status.
- Outputs drive the voice oscillator/envelope bank directly.

---
 rtl/midi_pkg.sv | 26 ++
 rtl/midi_voice_alloc.sv | 67 ++++++
 rtl/midi_poly.sv | 136 +++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and message-length helper
// for the polyphonic MIDI decoder.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] BEND     = 4'hE;

   localparam logic [7:0]  SYS_RESET   = 8'hFF;
   localparam logic [13:0] BEND_CENTRE = 14'h2000;

   typedef enum logic [1:0] {
      IDLE,
      D1,
      D2
   } parse_t;

   function automatic logic [1:0] data_len(input logic [3:0] nib);
      data_len = (nib == PROG || nib == CH_AT) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/midi_voice_alloc.sv
// Polyphonic note table: same-note match, lowest-free-slot allocation
// and overflow pulse when every slot is busy.
module midi_voice_alloc #(
   parameter int VOICES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  note_on,
   input  logic                  note_off,
   input  logic [6:0]            note,
   input  logic [6:0]            vel,
   output logic [7*VOICES-1:0]   note_num,
   output logic [7*VOICES-1:0]   note_vel,
   output logic [VOICES-1:0]     gate,
   output logic                  overflow
);

   logic [VOICES-1:0] hit;
   logic [VOICES-1:0] alloc;
   logic              found;

   always_comb begin
      hit   = '0;
      alloc = '0;
      found = 1'b0;
      for (int i = 0; i < VOICES; i++) begin
         hit[i] = gate[i] && (note_num[7*i +: 7] == note);
         if (!gate[i] && !found) begin
            alloc[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_num <= '0;
         note_vel <= '0;
         gate     <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         note_num <= '0;
         note_vel <= '0;
         gate     <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= note_on && !(|hit) && !found;
         for (int i = 0; i < VOICES; i++) begin
            if (note_on && (|hit)) begin
               if (hit[i])
                  note_vel[7*i +: 7] <= vel;
            end else if (note_on) begin
               if (alloc[i]) begin
                  note_num[7*i +: 7] <= note;
                  note_vel[7*i +: 7] <= vel;
                  gate[i]            <= 1'b1;
               end
            end else if (note_off && hit[i]) begin
               note_vel[7*i +: 7] <= 7'd0;
               gate[i]            <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/midi_poly.sv
// MIDI byte-stream parser with running status, channel filter,
// program/pitch-bend registers and a polyphonic voice table.
module midi_poly
   import midi_pkg::*;
#(
   parameter int         VOICES  = 4,
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic [7:0]            data,
   input  logic                  dv,
   output logic [7*VOICES-1:0]   note_num,
   output logic [7*VOICES-1:0]   note_vel,
   output logic [VOICES-1:0]     gate,
   output logic [6:0]            program_num,
   output logic [13:0]           pitch_bend,
   output logic                  overflow
);

   parse_t     state, state_n;
   logic [7:0] status, status_n;
   logic [6:0] d1, d1_n;
   logic       exec;
   logic       sys_clr;
   logic       accept;
   logic [3:0] nib;
   logic       run;
   logic [6:0] b1;
   logic [6:0] b2;
   logic       note_on;
   logic       note_off;

   assign accept = ce && dv;
   assign nib    = status[7:4];

   always_comb begin
      state_n  = state;
      status_n = status;
      d1_n     = d1;
      exec     = 1'b0;
      sys_clr  = 1'b0;
      if (accept) begin
         unique case (1'b1)
            (data == SYS_RESET):
               sys_clr = 1'b1;
            (data[7:3] == 5'b11111 && data != SYS_RESET): ;
            (data[7:3] == 5'b11110): begin
               state_n  = IDLE;
               status_n = 8'h00;
            end
            (data[7] && data[7:4] != 4'hF): begin
               status_n = data;
               state_n  = D1;
            end
            (!data[7]): begin
               unique case (state)
                  D1: begin
                     if (data_len(nib) == 2'd1) begin
                        exec = 1'b1;
                     end else begin
                        d1_n    = data[6:0];
                        state_n = D2;
                     end
                  end
                  D2: begin
                     exec    = 1'b1;
                     state_n = D1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         status <= 8'h00;
         d1     <= 7'd0;
      end else if (sys_clr) begin
         state  <= IDLE;
         status <= 8'h00;
         d1     <= 7'd0;
      end else begin
         state  <= state_n;
         status <= status_n;
         d1     <= d1_n;
      end
   end

   // Off-channel messages are still counted so running status stays aligned
   assign run = exec && (OMNI || status[3:0] == CHANNEL);
   assign b1  = (state == D2) ? d1 : data[6:0];
   assign b2  = data[6:0];

   assign note_on  = run && nib == NOTE_ON && b2 != 7'd0;
   assign note_off = run && (nib == NOTE_OFF ||
                             (nib == NOTE_ON && b2 == 7'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         program_num <= 7'd0;
         pitch_bend  <= BEND_CENTRE;
      end else if (sys_clr) begin
         program_num <= 7'd0;
         pitch_bend  <= BEND_CENTRE;
      end else if (run) begin
         if (nib == PROG)
            program_num <= b2;
         if (nib == BEND)
            pitch_bend <= {b2, d1};
      end
   end

   midi_voice_alloc #(
      .VOICES (VOICES)
   ) u_alloc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (sys_clr),
      .note_on  (note_on),
      .note_off (note_off),
      .note     (b1),
      .vel      (b2),
      .note_num (note_num),
      .note_vel (note_vel),
      .gate     (gate),
      .overflow (overflow)
   );

endmodule
